// File: rtl/p_s_converter_if.sv
// Load-side handshake bundle for p_s_converter.
// Ports: LOAD_VALID, LOAD_DATA (source to converter), LOAD_READY (converter to source).
interface p_s_converter_if #(
    parameter int C_BITS_OUT = 255
) ();
    logic                  LOAD_VALID;
    logic [C_BITS_OUT-1:0] LOAD_DATA;
    logic                  LOAD_READY;

    modport master (
        output LOAD_VALID,
        output LOAD_DATA,
        input  LOAD_READY
    );

    modport slave (
        input  LOAD_VALID,
        input  LOAD_DATA,
        output LOAD_READY
    );
endinterface

// File: rtl/p_s_converter.sv
// Parallel-to-serial converter: one-word buffer, free-running MSB-first frames.
// Ports: CK, RST (sync, active high), ld (load handshake slave),
//        D (serial out), FRAME_START, UNDERRUN (fill-frame pulse).
// Option: define P_S_REPEAT_LAST_EN to make fill frames repeat the last word.
module p_s_converter #(
    parameter int C_BITS_OUT = 255
) (
    input  logic             CK,
    input  logic             RST,
    p_s_converter_if.slave   ld,
    output logic             D,
    output logic             FRAME_START,
    output logic             UNDERRUN
);
    localparam int CW = (C_BITS_OUT > 1) ? $clog2(C_BITS_OUT) : 1;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [C_BITS_OUT-1:0] sh_q, sh_d;
    logic [C_BITS_OUT-1:0] buf_q, buf_d;
    logic                  buf_full_q, buf_full_d;
    logic                  fs_q, fs_d;
    logic                  ur_q, ur_d;
    logic [C_BITS_OUT-1:0] fill;
    logic                  load;
    logic                  accept;

`ifdef P_S_REPEAT_LAST_EN
    logic [C_BITS_OUT-1:0] last_q, last_d;

    assign fill = last_q;

    always_comb begin
        last_d = last_q;
        if (load && buf_full_q) begin
            last_d = buf_q;
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            last_q <= '0;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign fill = '0;
`endif

    assign load   = (cnt_q == '0);
    assign accept = ld.LOAD_VALID && !buf_full_q;

    always_comb begin
        cnt_d      = cnt_q + CW'(1);
        sh_d       = {sh_q[C_BITS_OUT-2:0], 1'b0};
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        fs_d       = 1'b0;
        ur_d       = 1'b0;

        if (cnt_q == CW'(C_BITS_OUT - 1)) begin
            cnt_d = '0;
        end

        // Accept and load never collide on a full buffer: accept needs it
        // empty, so a word taken on a load edge waits for the next frame.
        if (accept) begin
            buf_d      = ld.LOAD_DATA;
            buf_full_d = 1'b1;
        end

        if (load) begin
            fs_d = 1'b1;
            if (buf_full_q) begin
                sh_d       = buf_q;
                buf_full_d = 1'b0;
            end else begin
                sh_d = fill;
                ur_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            cnt_q      <= '0;
            sh_q       <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            fs_q       <= 1'b0;
            ur_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            fs_q       <= fs_d;
            ur_q       <= ur_d;
        end
    end

    assign D             = sh_q[C_BITS_OUT-1];
    assign FRAME_START   = fs_q;
    assign UNDERRUN      = ur_q;
    assign ld.LOAD_READY = !buf_full_q;
endmodule

// File: tb/tb_p_s_converter.sv
// Scoreboard bench for p_s_converter with C_BITS_OUT=8.
// Stimulus pushes expected frames; a monitor deserialises D and compares.
module tb_p_s_converter;
    localparam int N = 8;

    typedef struct {
        logic [N-1:0] w;
        logic         ur;
    } frame_t;

    logic CK = 1'b0;
    logic RST = 1'b1;
    logic D, FRAME_START, UNDERRUN;

    int checks = 0;
    int errors = 0;

    frame_t exp_q[$];

    p_s_converter_if #(.C_BITS_OUT(N)) ld_if ();

    p_s_converter #(.C_BITS_OUT(N)) dut (
        .CK          (CK),
        .RST         (RST),
        .ld          (ld_if.slave),
        .D           (D),
        .FRAME_START (FRAME_START),
        .UNDERRUN    (UNDERRUN)
    );

    always #5 CK = ~CK;

    // Monitor: collect N bits starting at FRAME_START, compare to queue head.
    logic [N-1:0] mon_sh;
    logic         mon_ur;
    logic         mon_act = 1'b0;
    int           mon_n = 0;

    always @(negedge CK) begin
        frame_t e;
        if (RST) begin
            mon_act = 1'b0;
            mon_n   = 0;
        end else begin
            if (FRAME_START) begin
                mon_act = 1'b1;
                mon_n   = 0;
                mon_ur  = UNDERRUN;
                mon_sh  = '0;
            end
            if (mon_act) begin
                mon_sh = {mon_sh[N-2:0], D};
                mon_n++;
                if (mon_n == N) begin
                    mon_act = 1'b0;
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        checks++;
                        if (mon_sh !== e.w || mon_ur !== e.ur) begin
                            errors++;
                            $display("FAIL frame: got word %h ur %b, expected word %h ur %b",
                                     mon_sh, mon_ur, e.w, e.ur);
                        end
                    end
                end
            end
        end
    end

    task automatic push(input logic [N-1:0] w, input logic ur);
        frame_t f;
        f.w  = w;
        f.ur = ur;
        exp_q.push_back(f);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Ends #1 after the reset edge (P0); next edge P1 is the first load edge.
    task automatic do_reset();
        @(posedge CK);
        #1 RST = 1'b1;
        @(posedge CK);
        #1 RST = 1'b0;
        check("reset_d", 32'(D), 32'h0);
        check("reset_ready", 32'(ld_if.LOAD_READY), 32'h1);
        check("reset_fs", 32'(FRAME_START), 32'h0);
    endtask

    task automatic send(input logic [N-1:0] w);
        logic acc;
        int   n;
        ld_if.LOAD_VALID = 1'b1;
        ld_if.LOAD_DATA  = w;
        n = 0;
        do begin
            acc = ld_if.LOAD_READY;
            @(posedge CK);
            #1;
            n++;
        end while (!acc && n < 64);
        if (!acc) begin
            errors++;
            $display("FAIL send_timeout: word %h not accepted", w);
        end
        ld_if.LOAD_VALID = 1'b0;
    endtask

    task automatic idle_check(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge CK);
            check("idle_d", 32'(D), 32'h0);
            check("idle_ready", 32'(ld_if.LOAD_READY), 32'h1);
            check("idle_fs", 32'(FRAME_START), 32'((c % N) == 1));
            check("idle_ur", 32'(UNDERRUN), 32'((c % N) == 1));
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 64; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge CK);
        end
        @(posedge CK);
        #1;
        check("drain_q", 32'(exp_q.size()), 32'h0);
        exp_q.delete();
    endtask

    initial begin
        ld_if.LOAD_VALID = 1'b0;
        ld_if.LOAD_DATA  = '0;

        // Idle: fill frames at cycles 1, 9, 17.
        do_reset();
        push(8'h00, 1'b1);
        push(8'h00, 1'b1);
        push(8'h00, 1'b1);
        idle_check(24);
        drain();

        // Single word accepted on the first load edge.
        do_reset();
        push(8'h00, 1'b1);
        push(8'hA5, 1'b0);
        ld_if.LOAD_VALID = 1'b1;
        ld_if.LOAD_DATA  = 8'hA5;
        for (int k = 1; k <= 9; k++) begin
            @(posedge CK);
            #1;
            ld_if.LOAD_VALID = 1'b0;
            check("a5_ready", 32'(ld_if.LOAD_READY), 32'(k >= 9));
        end
        drain();

        // Back-to-back words.
        do_reset();
        push(8'h00, 1'b1);
        push(8'h01, 1'b0);
        push(8'h80, 1'b0);
        push(8'hFF, 1'b0);
        send(8'h01);
        send(8'h80);
        send(8'hFF);
        drain();

        // Word arriving on a load edge with empty buffer.
        do_reset();
        push(8'h00, 1'b1);
        push(8'h00, 1'b1);
        push(8'h3C, 1'b0);
        repeat (8) @(posedge CK);
        #1;
        send(8'h3C);
        drain();

        // Reset mid-frame discards both in-flight and buffered words.
        do_reset();
        push(8'h00, 1'b1);
        send(8'hF0);
        send(8'h0F);
        repeat (2) @(posedge CK);
        #1 RST = 1'b1;
        check("pre_rst_fs_seen", 32'(exp_q.size()), 32'h0);
        @(posedge CK);
        #1 RST = 1'b0;
        check("rst_d", 32'(D), 32'h0);
        check("rst_ready", 32'(ld_if.LOAD_READY), 32'h1);
        push(8'h00, 1'b1);
        push(8'h00, 1'b1);
        push(8'h00, 1'b1);
        idle_check(24);
        drain();

`ifdef P_S_REPEAT_LAST_EN
        // Fill frames repeat the last word.
        do_reset();
        push(8'h00, 1'b1);
        push(8'h5A, 1'b0);
        push(8'h5A, 1'b1);
        push(8'h5A, 1'b1);
        send(8'h5A);
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/p_s_converter.md
# p_s_converter

Parallel-to-serial converter sitting directly upstream of the serial-to-parallel stage. It accepts parallel words over a valid/ready handshake, buffers one word, and streams each word MSB-first as a contiguous, fixed-length frame of C_BITS_OUT bits on a single serial line. Framing is free-running from reset, so a downstream deserializer reset by the same RST and clocked by the same CK stays frame-aligned. If no word is available at a frame boundary, the block emits a fill frame and flags an underrun.

## Interface

- C_BITS_OUT, default 255: frame length in bits and width of the parallel input word; legal range is 2 or more.
- CK  in  1: clock; all state updates on the rising edge.
- RST  in  1: synchronous, active-high reset.
- LOAD_VALID  in  1: LOAD_DATA holds a word to transfer.
- LOAD_DATA  in  C_BITS_OUT: parallel word; bit C_BITS_OUT-1 is transmitted first.
- LOAD_READY  out  1: the holding buffer is empty and can accept a word.
- D  out  1: serial data line to the downstream stage.
- FRAME_START  out  1: high during the cycle in which D carries bit C_BITS_OUT-1 of a frame.
- UNDERRUN  out  1: one-cycle pulse, coincident with FRAME_START, when the current frame is a fill frame.

## Operation

- State elements:
  - bit counter `cnt`, range 0..C_BITS_OUT-1, width clog2(C_BITS_OUT);
  - shift register `sh` of C_BITS_OUT bits;
  - holding buffer `buf` with flag `buf_full`;
  - registered FRAME_START;
  - registered UNDERRUN.
- D is sh[C_BITS_OUT-1], driven directly from the register with no combinational path from the inputs. LOAD_READY = !buf_full.
- Handshake:
  - A word is accepted on any edge with LOAD_VALID && LOAD_READY. buf takes LOAD_DATA and buf_full is set.
  - While LOAD_READY is low, LOAD_DATA is ignored.
  - The source holds LOAD_DATA stable while LOAD_VALID is high and LOAD_READY is low.
- Load edge (cnt==0 and RST low):
  - If buf_full: sh is loaded from buf, buf_full is cleared, and UNDERRUN is set to 0.
  - Otherwise: sh is loaded with the fill word and UNDERRUN is set to 1.
  - FRAME_START is set to 1.
- Shift edge (cnt!=0): sh shifts left by one with 0 shifted in. FRAME_START and UNDERRUN are set to 0.
- Counter: cnt increments each cycle and wraps from C_BITS_OUT-1 to 0.
- Simultaneous accept and load on one edge:
  - This can only happen when buf is empty at the load edge.
  - The current frame is a fill frame (UNDERRUN=1).
  - The accepted word goes to buf and is sent in the next frame. A word never bypasses buf.
- With buf full at a load edge, buf drains into sh. LOAD_READY rises the next cycle.
- Fill word is all zeros (see Configuration).

## Timing

- Reset values: cnt=0, sh=0, buf=0, buf_full=0, FRAME_START=0, UNDERRUN=0. This gives D=0 and LOAD_READY=1.
- RST asserted mid-frame: all state returns to reset values on that edge, the in-flight frame and buffered word are discarded, and D=0 on the following cycle.
- The first edge with RST low is a load edge. D carries bit C_BITS_OUT-1 of frame 0 in the cycle after it, together with FRAME_START=1.
- A new frame starts every C_BITS_OUT cycles with no gaps. Bit k of a frame (k = C_BITS_OUT-1 down to 0) appears on D in cycle C_BITS_OUT-1-k of the frame.
- Latency: a word accepted on edge t with buf empty and at least one edge remaining before the next load edge appears at that load edge. Its MSB is on D one cycle after that load edge.
- Throughput: one word per C_BITS_OUT cycles. The single buffer absorbs one word of jitter.

## Configuration

- P_S_REPEAT_LAST_EN:
  - Defined: an extra C_BITS_OUT-bit register `last` (reset 0) is updated with every word loaded from buf. A fill frame transmits `last`, so the downstream output holds its previous value. UNDERRUN still pulses.
  - Undefined: `last` is absent and fill frames are all zeros.

## Test plan

All scenarios use C_BITS_OUT=8.

- Reset, then present nothing for 24 cycles. Required: D=0 throughout; FRAME_START and UNDERRUN pulse together at cycles 1, 9 and 17 after reset release; LOAD_READY=1.
- Drive LOAD_VALID with 0xA5 on the first edge after reset release. Required: frame 0 is fill with UNDERRUN=1; frame 1 puts 1,0,1,0,0,1,0,1 on D; LOAD_READY is 0 from acceptance until the cycle after frame 1's load edge.
- Hold LOAD_VALID high with the sequence 0x01, 0x80, 0xFF. Required: back-to-back frames carry those words in order; UNDERRUN stays 0 after the first frame; every word is accepted exactly once.
- Assert LOAD_VALID with 0x3C in the same cycle as a load edge while buf is empty. Required: the current frame is fill with UNDERRUN=1, and 0x3C is sent in the next frame.
- Assert RST for one cycle at bit 4 of a frame carrying 0xF0, with 0x0F buffered. Required: D=0 and LOAD_READY=1 after reset; 0x0F is never transmitted; framing restarts as in the first scenario.
- With P_S_REPEAT_LAST_EN defined, send 0x5A then stall the source. Required: the following frames repeat 0x5A with UNDERRUN=1 each frame.
